i2c_bus_scheduler: RTL and testbench

Shares one i2c_master core between NUM_REQ requesters, for example several TLV493 sensor FSMs on a common SDA/SCL pair. Requesters are served round-robin. The block latches the granted requester's transaction fields and drives the master's ena/addr/rw/data_wr/number_of_bytes/read_only. It detects completion from byte_counter or ack_error and returns a one-cycle done pulse to the requester. A watchdog resets a hung master.

---
 rtl/i2c_bus_scheduler.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2c_bus_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_scheduler.sv
// i2c_bus_scheduler: round-robin sharing of one i2c_master core between NUM_REQ
// requesters. It latches the granted request and drives the master, detects
// completion, and resets the master when the watchdog expires.
module i2c_bus_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned RECOVER_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [7*NUM_REQ-1:0]    req_addr,
    input  logic [NUM_REQ-1:0]      req_rw,
    input  logic [NUM_REQ-1:0]      req_read_only,
    input  logic [8*NUM_REQ-1:0]    req_nbytes,
    input  logic [32*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_grant,
    output logic [NUM_REQ-1:0]      req_done,
    output logic                    req_ack_error,
    output logic                    req_timeout,
    output logic                    m_ena,
    output logic [6:0]              m_addr,
    output logic                    m_rw,
    output logic                    m_read_only,
    output logic [7:0]              m_nbytes,
    output logic [31:0]             m_wdata,
    output logic                    m_reset_n,
    input  logic                    m_busy,
    input  logic [7:0]              m_byte_counter,
    input  logic                    m_ack_error
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARB     = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_RECOVER = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]         state, state_nx;
    logic [PW-1:0]      rr_ptr, rr_ptr_nx;
    logic [PW-1:0]      gidx, gidx_nx;
    logic [WW-1:0]      wdog, wdog_nx;
    logic [RW-1:0]      rcnt, rcnt_nx;
    logic               ack_flag, ack_flag_nx;
    logic               to_flag, to_flag_nx;
    logic [6:0]         lat_addr, lat_addr_nx;
    logic               lat_rw, lat_rw_nx;
    logic               lat_ro, lat_ro_nx;
    logic [7:0]         lat_nbytes, lat_nbytes_nx;
    logic [31:0]        lat_wdata, lat_wdata_nx;

    logic [NUM_REQ-1:0] grant_nx, done_nx;
    logic               ack_out_nx, to_out_nx;
    logic               m_ena_nx, m_rw_nx, m_ro_nx, m_reset_n_nx;
    logic [6:0]         m_addr_nx;
    logic [7:0]         m_nbytes_nx;
    logic [31:0]        m_wdata_nx;

    logic               arb_found;
    logic [PW-1:0]      arb_idx;
    logic [PW:0]        arb_sum;
    logic               wdog_expired;

    assign wdog_expired = (wdog == WW'(TIMEOUT_CYCLES - 1));

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            arb_sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (arb_sum >= (PW+1)'(NUM_REQ))
                arb_sum = arb_sum - (PW+1)'(NUM_REQ);
            if (!arb_found && req_valid[arb_sum[PW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_sum[PW-1:0];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx      = state;
        rr_ptr_nx     = rr_ptr;
        gidx_nx       = gidx;
        wdog_nx       = wdog;
        rcnt_nx       = rcnt;
        ack_flag_nx   = ack_flag;
        to_flag_nx    = to_flag;
        lat_addr_nx   = lat_addr;
        lat_rw_nx     = lat_rw;
        lat_ro_nx     = lat_ro;
        lat_nbytes_nx = lat_nbytes;
        lat_wdata_nx  = lat_wdata;
        grant_nx      = req_grant;
        done_nx       = '0;
        ack_out_nx    = 1'b0;
        to_out_nx     = 1'b0;
        m_ena_nx      = m_ena;
        m_addr_nx     = m_addr;
        m_rw_nx       = m_rw;
        m_ro_nx       = m_read_only;
        m_nbytes_nx   = m_nbytes;
        m_wdata_nx    = m_wdata;
        m_reset_n_nx  = m_reset_n;

        case (state)
            S_IDLE: begin
                if (req_valid != '0)
                    state_nx = S_ARB;
            end
            S_ARB: begin
                if (arb_found) begin
                    gidx_nx       = arb_idx;
                    grant_nx      = NUM_REQ'(1) << arb_idx;
                    lat_addr_nx   = req_addr[int'(arb_idx)*7 +: 7];
                    lat_rw_nx     = req_rw[arb_idx];
                    lat_ro_nx     = req_read_only[arb_idx];
                    lat_nbytes_nx = req_nbytes[int'(arb_idx)*8 +: 8];
                    lat_wdata_nx  = req_wdata[int'(arb_idx)*32 +: 32];
                    ack_flag_nx   = 1'b0;
                    to_flag_nx    = 1'b0;
                    state_nx      = (req_nbytes[int'(arb_idx)*8 +: 8] == 8'd0) ? S_DONE : S_ISSUE;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_ISSUE: begin
                m_addr_nx   = lat_addr;
                m_rw_nx     = lat_rw;
                m_ro_nx     = lat_ro;
                m_nbytes_nx = lat_nbytes;
                m_wdata_nx  = lat_wdata;
                m_ena_nx    = 1'b1;
                wdog_nx     = '0;
                state_nx    = S_RUN;
            end
            S_RUN: begin
                if (m_ack_error || (m_byte_counter >= lat_nbytes)) begin
                    m_ena_nx    = 1'b0;
                    ack_flag_nx = m_ack_error;
                    state_nx    = S_DRAIN;
                end else if (wdog_expired) begin
                    m_ena_nx     = 1'b0;
                    to_flag_nx   = 1'b1;
                    m_reset_n_nx = 1'b0;
                    rcnt_nx      = '0;
                    state_nx     = S_RECOVER;
                end else begin
                    wdog_nx = wdog + WW'(1);
                end
            end
            S_DRAIN: begin
                if (!m_busy) begin
                    state_nx = S_DONE;
                end else if (wdog_expired) begin
                    to_flag_nx   = 1'b1;
                    m_reset_n_nx = 1'b0;
                    rcnt_nx      = '0;
                    state_nx     = S_RECOVER;
                end else begin
                    wdog_nx = wdog + WW'(1);
                end
            end
            S_RECOVER: begin
                if (rcnt == RW'(RECOVER_CYCLES - 1)) begin
                    m_reset_n_nx = 1'b1;
                    state_nx     = S_DONE;
                end else begin
                    rcnt_nx = rcnt + RW'(1);
                end
            end
            S_DONE: begin
                grant_nx  = '0;
                rr_ptr_nx = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
                state_nx  = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Registered done pulse lines up with the single DONE cycle.
        if (state_nx == S_DONE) begin
            done_nx    = grant_nx;
            ack_out_nx = ack_flag_nx;
            to_out_nx  = to_flag_nx;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            gidx          <= '0;
            wdog          <= '0;
            rcnt          <= '0;
            ack_flag      <= 1'b0;
            to_flag       <= 1'b0;
            lat_addr      <= '0;
            lat_rw        <= 1'b0;
            lat_ro        <= 1'b0;
            lat_nbytes    <= '0;
            lat_wdata     <= '0;
            req_grant     <= '0;
            req_done      <= '0;
            req_ack_error <= 1'b0;
            req_timeout   <= 1'b0;
            m_ena         <= 1'b0;
            m_addr        <= '0;
            m_rw          <= 1'b0;
            m_read_only   <= 1'b0;
            m_nbytes      <= '0;
            m_wdata       <= '0;
            m_reset_n     <= 1'b1;
        end else begin
            state         <= state_nx;
            rr_ptr        <= rr_ptr_nx;
            gidx          <= gidx_nx;
            wdog          <= wdog_nx;
            rcnt          <= rcnt_nx;
            ack_flag      <= ack_flag_nx;
            to_flag       <= to_flag_nx;
            lat_addr      <= lat_addr_nx;
            lat_rw        <= lat_rw_nx;
            lat_ro        <= lat_ro_nx;
            lat_nbytes    <= lat_nbytes_nx;
            lat_wdata     <= lat_wdata_nx;
            req_grant     <= grant_nx;
            req_done      <= done_nx;
            req_ack_error <= ack_out_nx;
            req_timeout   <= to_out_nx;
            m_ena         <= m_ena_nx;
            m_addr        <= m_addr_nx;
            m_rw          <= m_rw_nx;
            m_read_only   <= m_ro_nx;
            m_nbytes      <= m_nbytes_nx;
            m_wdata       <= m_wdata_nx;
            m_reset_n     <= m_reset_n_nx;
        end
    end

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// tb_i2c_bus_scheduler: directed and randomized transactions against a
// behavioural round-robin model, with a simple i2c_master stand-in.
module tb_i2c_bus_scheduler;

    localparam int N  = 4;
    localparam int TO = 100;
    localparam int RC = 4;

    logic           clock;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [7*N-1:0] req_addr;
    logic [N-1:0]   req_rw;
    logic [N-1:0]   req_read_only;
    logic [8*N-1:0] req_nbytes;
    logic [32*N-1:0] req_wdata;
    logic [N-1:0]   req_grant;
    logic [N-1:0]   req_done;
    logic           req_ack_error;
    logic           req_timeout;
    logic           m_ena;
    logic [6:0]     m_addr;
    logic           m_rw;
    logic           m_read_only;
    logic [7:0]     m_nbytes;
    logic [31:0]    m_wdata;
    logic           m_reset_n;
    logic           mb_busy;
    logic [7:0]     mb_cnt;
    logic           mb_ack;

    i2c_bus_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO), .RECOVER_CYCLES(RC)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_rw(req_rw),
        .req_read_only(req_read_only), .req_nbytes(req_nbytes), .req_wdata(req_wdata),
        .req_grant(req_grant), .req_done(req_done),
        .req_ack_error(req_ack_error), .req_timeout(req_timeout),
        .m_ena(m_ena), .m_addr(m_addr), .m_rw(m_rw), .m_read_only(m_read_only),
        .m_nbytes(m_nbytes), .m_wdata(m_wdata), .m_reset_n(m_reset_n),
        .m_busy(mb_busy), .m_byte_counter(mb_cnt), .m_ack_error(mb_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Master stand-in: one byte per 3 clocks while ena; NACK at byte mb_nack_at; busy lingers 2 clocks.
    int mb_nack_at;
    bit mb_stall;
    int mb_tick;
    int mb_tail;
    always @(posedge clock) begin
        if (reset || !m_reset_n) begin
            mb_busy <= 1'b0; mb_cnt <= 8'd0; mb_ack <= 1'b0; mb_tick <= 0; mb_tail <= 0;
        end else if (m_ena) begin
            mb_busy <= 1'b1;
            mb_tail <= 2;
            if (!mb_stall) begin
                if (mb_tick == 2) begin
                    mb_tick <= 0;
                    mb_cnt  <= mb_cnt + 8'd1;
                    if (int'(mb_cnt) + 1 == mb_nack_at) mb_ack <= 1'b1;
                end else begin
                    mb_tick <= mb_tick + 1;
                end
            end
        end else if (mb_tail != 0) begin
            mb_tail <= mb_tail - 1;
            if (mb_tail == 1) begin
                mb_busy <= 1'b0; mb_cnt <= 8'd0; mb_ack <= 1'b0; mb_tick <= 0;
            end
        end
    end

    // Passive monitor: cumulative counters and field capture at ena rise.
    int ena_total = 0, rstlow_total = 0, done_total = 0, multi_grant = 0, stab_err = 0;
    logic ena_prev = 1'b0;
    logic [6:0] cap_addr;
    logic cap_rw, cap_ro;
    logic [7:0] cap_nb;
    logic [31:0] cap_wd;
    always @(negedge clock) begin
        if (m_ena) begin
            ena_total <= ena_total + 1;
            if (!ena_prev) begin
                cap_addr <= m_addr; cap_rw <= m_rw; cap_ro <= m_read_only;
                cap_nb <= m_nbytes; cap_wd <= m_wdata;
            end else if (m_addr != cap_addr || m_rw != cap_rw || m_read_only != cap_ro ||
                         m_nbytes != cap_nb || m_wdata != cap_wd) begin
                stab_err <= stab_err + 1;
            end
        end
        ena_prev <= m_ena;
        if (!m_reset_n) rstlow_total <= rstlow_total + 1;
        if (req_done != '0) done_total <= done_total + 1;
        if ($countones(req_grant) > 1) multi_grant <= multi_grant + 1;
    end

    int n_pass = 0, n_fail = 0, n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state and expectations for the pending transaction.
    int ptr;
    int exp_k, exp_ena, exp_rst;
    logic exp_ack, exp_to, exp_rw, exp_ro;
    logic [6:0] exp_addr;
    logic [7:0] exp_nb;
    logic [31:0] exp_wd;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++)
            if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic set_slice(input int k, input logic [6:0] a, input logic rw, input logic ro,
                             input logic [7:0] nb, input logic [31:0] wd);
        req_addr[k*7 +: 7]    = a;
        req_rw[k]             = rw;
        req_read_only[k]      = ro;
        req_nbytes[k*8 +: 8]  = nb;
        req_wdata[k*32 +: 32] = wd;
    endtask

    task automatic rand_fields();
        for (int k = 0; k < N; k++)
            set_slice(k, 7'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 20)), $urandom);
    endtask

    task automatic scramble_inputs();
        req_valid     = N'($urandom);
        req_addr      = (7*N)'($urandom);
        req_rw        = N'($urandom);
        req_read_only = N'($urandom);
        req_nbytes    = (8*N)'($urandom);
        req_wdata     = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Expected outcome from the requester's fields and the master's behaviour.
    task automatic plan(input int k, input int nack, input bit stall);
        int stop;
        exp_k = k;
        exp_addr = req_addr[k*7 +: 7];
        exp_rw = req_rw[k];
        exp_ro = req_read_only[k];
        exp_nb = req_nbytes[k*8 +: 8];
        exp_wd = req_wdata[k*32 +: 32];
        mb_nack_at = nack;
        mb_stall = stall;
        if (exp_nb == 8'd0) begin
            exp_ack = 1'b0; exp_to = 1'b0; exp_ena = 0; exp_rst = 0;
        end else if (stall) begin
            exp_ack = 1'b0; exp_to = 1'b1; exp_ena = TO; exp_rst = RC;
        end else begin
            exp_ack = (nack != 0 && nack <= int'(exp_nb));
            stop = exp_ack ? nack : int'(exp_nb);
            exp_to = 1'b0; exp_ena = 3 * stop + 1; exp_rst = 0;
        end
    endtask

    task automatic expect_txn(input string tag, input bit scramble);
        int e0, r0;
        bit got, seen_ena;
        e0 = ena_total; r0 = rstlow_total; got = 0; seen_ena = 0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clock);
            if (req_done != '0) begin
                got = 1;
            end else if (m_ena && !seen_ena) begin
                seen_ena = 1;
                chk({tag, "_grant"}, 64'(req_grant), 64'(N'(1) << exp_k));
                if (scramble) scramble_inputs();
            end
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, "_done_vec"}, 64'(req_done), 64'(N'(1) << exp_k));
            chk({tag, "_ack_error"}, 64'(req_ack_error), 64'(exp_ack));
            chk({tag, "_timeout"}, 64'(req_timeout), 64'(exp_to));
            chk({tag, "_ena_cycles"}, 64'(ena_total - e0), 64'(exp_ena));
            chk({tag, "_reset_low"}, 64'(rstlow_total - r0), 64'(exp_rst));
            if (exp_nb != 8'd0) begin
                chk({tag, "_m_addr"}, 64'(cap_addr), 64'(exp_addr));
                chk({tag, "_m_rw"}, 64'(cap_rw), 64'(exp_rw));
                chk({tag, "_m_ro"}, 64'(cap_ro), 64'(exp_ro));
                chk({tag, "_m_nbytes"}, 64'(cap_nb), 64'(exp_nb));
                chk({tag, "_m_wdata"}, 64'(cap_wd), 64'(exp_wd));
            end
            @(negedge clock);
            chk({tag, "_pulse_width"}, 64'(req_done), 64'd0);
            chk({tag, "_ungrant"}, 64'(req_grant), 64'd0);
        end
    endtask

    initial begin
        int k, nack, d0;
        logic [N-1:0] v;
        bit ena_up;
        reset = 1'b1;
        req_valid = '0; req_addr = '0; req_rw = '0; req_read_only = '0;
        req_nbytes = '0; req_wdata = '0;
        mb_nack_at = 0; mb_stall = 0; ptr = 0;
        repeat (3) @(negedge clock);

        // Reset values.
        chk("rst_grant", 64'(req_grant), 64'd0);
        chk("rst_done", 64'(req_done), 64'd0);
        chk("rst_ack", 64'(req_ack_error), 64'd0);
        chk("rst_to", 64'(req_timeout), 64'd0);
        chk("rst_ena", 64'(m_ena), 64'd0);
        chk("rst_addr", 64'(m_addr), 64'd0);
        chk("rst_nbytes", 64'(m_nbytes), 64'd0);
        chk("rst_wdata", 64'(m_wdata), 64'd0);
        chk("rst_reset_n", 64'(m_reset_n), 64'd1);
        reset = 1'b0;
        @(negedge clock);

        // Single request on slice 1 with issue latency.
        set_slice(1, 7'h5e, 1'b1, 1'b0, 8'd7, 32'hcafe_0001);
        plan(1, 0, 0);
        req_valid = 4'b0010;
        @(negedge clock);
        chk("t1_ena_arb", 64'(m_ena), 64'd0);
        @(negedge clock);
        chk("t1_ena_issue", 64'(m_ena), 64'd0);
        chk("t1_grant_issue", 64'(req_grant), 64'b0010);
        @(negedge clock);
        chk("t1_ena_run", 64'(m_ena), 64'd1);
        chk("t1_addr_run", 64'(m_addr), 64'h5e);
        chk("t1_nbytes_run", 64'(m_nbytes), 64'd7);
        req_valid = '0;
        expect_txn("t1", 0);
        ptr = 2;

        // All requesters held high for 8 turns.
        rand_fields();
        for (int i = 0; i < N; i++) req_nbytes[i*8 +: 8] = 8'($urandom_range(1, 10));
        req_valid = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            k = pick(req_valid, ptr);
            plan(k, 0, 0);
            expect_txn("rr", 0);
            ptr = (k + 1) % N;
        end
        req_valid = '0;

        // NACK at byte 2 of 4 on slice 2.
        set_slice(2, 7'h1a, 1'b0, 1'b0, 8'd4, 32'h1234_5678);
        plan(2, 2, 0);
        req_valid = 4'b0100;
        expect_txn("nack", 0);
        req_valid = '0;
        ptr = 3;

        // Stalled master on slice 0 triggers the watchdog.
        set_slice(0, 7'h35, 1'b1, 1'b1, 8'd5, 32'h0);
        plan(0, 0, 1);
        req_valid = 4'b0001;
        expect_txn("wdog", 0);
        req_valid = '0;
        mb_stall = 0;
        ptr = 1;

        // Zero-length request on slice 3.
        set_slice(3, 7'h22, 1'b0, 1'b0, 8'd0, 32'hffff_ffff);
        plan(3, 0, 0);
        req_valid = 4'b1000;
        expect_txn("zero", 0);
        req_valid = '0;
        ptr = 0;

        // Randomized requests with request inputs disturbed mid-transaction.
        for (int t = 0; t < 16; t++) begin
            rand_fields();
            v = N'($urandom_range(1, 15));
            req_valid = v;
            k = pick(v, ptr);
            nack = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 22)) : 0;
            plan(k, nack, 0);
            expect_txn("rnd", 1);
            ptr = (k + 1) % N;
        end
        req_valid = '0;

        // Asynchronous reset while RUN is in progress.
        set_slice(1, 7'h11, 1'b0, 1'b0, 8'd20, 32'h5555_aaaa);
        plan(1, 0, 0);
        req_valid = 4'b0010;
        ena_up = 0;
        for (int c = 0; c < 20 && !ena_up; c++) begin
            @(negedge clock);
            ena_up = m_ena;
        end
        chk("ar_ena_up", 64'(ena_up), 64'd1);
        repeat (5) @(negedge clock);
        d0 = done_total;
        #2 reset = 1'b1;
        #1;
        chk("ar_ena", 64'(m_ena), 64'd0);
        chk("ar_grant", 64'(req_grant), 64'd0);
        chk("ar_done", 64'(req_done), 64'd0);
        chk("ar_reset_n", 64'(m_reset_n), 64'd1);
        chk("ar_addr", 64'(m_addr), 64'd0);
        req_valid = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("ar_no_done", 64'(done_total - d0), 64'd0);
        ptr = 0;
        rand_fields();
        for (int i = 0; i < N; i++) req_nbytes[i*8 +: 8] = 8'($urandom_range(1, 10));
        req_valid = 4'b1111;
        k = pick(req_valid, ptr);
        plan(k, 0, 0);
        expect_txn("ar_after", 0);
        req_valid = '0;

        chk("one_hot_grant", 64'(multi_grant), 64'd0);
        chk("m_fields_stable", 64'(stab_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
